fnd_font_capture: RTL and testbench
===================================

# fnd_font_capture

Scan-side capture block for the 4-digit multiplexed FND bus. It watches the active-low digit select and segment font lines and filters out multiplexing glitches. It decodes each stable font back to its 4-bit code and publishes a complete 4-digit frame with a one-cycle valid pulse. It sits beside the display driver as a readback/self-check path, and as the bench monitor for counter designs.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical registered samples required before a digit is accepted. Range 2..255.
- `TIMEOUT_CYCLES`, default 100000: cycles without a completed frame before `o_stale` asserts. Range ≥ 16.
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `i_clear`  in  1  synchronous clear of captured state. Priority over every other event.
- `i_digitSel`  in  4  active-low one-hot digit select. Bit0 is the least significant digit.
- `i_font`  in  8  active-low segments, bit7 = dp.
- `o_value`  out  16  captured frame, four 4-bit codes. Digit n occupies [4n+3:4n].
- `o_valid`  out  1  one-cycle pulse when `o_value` updates.
- `o_fontErr`  out  4  per-digit flag: the last frame held an undecodable font.
- `o_selErr`  out  1  sticky: an illegal select pattern was held for `STABLE_CYCLES`.
- `o_stale`  out  1  no frame completed within `TIMEOUT_CYCLES`.

## Operation
- Font map (font → code):
  - `c0`→0, `f9`→1, `a4`→2, `b0`→3, `99`→4, `92`→5, `82`→6, `f8`→7, `80`→8, `90`→9.
  - `7f` (dp only)→`a`.
  - `ff` (blank)→`f`.
  - Any other font→`e`, with the digit's error bit set.
- Input stage: `i_digitSel` and `i_font` are registered once into `r_sel`/`r_font`. A stability counter clears whenever either registered value differs from its previous-cycle value.
- State machine, two states:
  - S_WAIT: counter increments; when counter = `STABLE_CYCLES`−1 the sample is taken and the state moves to S_HELD.
  - S_HELD: no further sample. Returns to S_WAIT on any change of `r_sel`/`r_font`.
- Legal select means exactly one bit low. On taking a sample:
  - Legal select: the digit's code and error bit are written to the staging registers, and the digit's bit is set in the 4-bit seen-mask.
  - Illegal select (`1111`, or two or more bits low): `o_selErr` is set and staging is unchanged.
- Re-acceptance of an already-seen digit before the frame completes overwrites its staged code.
- Frame completion: the acceptance that makes the seen-mask `1111` loads the four staged codes into `o_value`/`o_fontErr` on that same edge. On that edge `o_valid` pulses, the mask clears and the timeout counter clears.
- Timeout: the counter increments every cycle while no frame completes. `o_stale` is set when it reaches `TIMEOUT_CYCLES`, saturates, and clears on the next frame completion.
- `i_clear` effect: mask, staging, `o_value`, `o_fontErr`, `o_selErr`, `o_stale`, stability counter and timeout counter all go to 0, and the state goes to S_WAIT. It outranks a same-cycle acceptance.

## Timing
- Reset values:
  - `o_value` = `0000`, `o_valid` = 0, `o_fontErr` = 0, `o_selErr` = 0, `o_stale` = 0.
  - State = S_WAIT, counters = 0, mask = 0.
  - `r_sel` = `f`, `r_font` = `ff`.
- Latency: a pattern present on the inputs before edge k and held is accepted on edge k+`STABLE_CYCLES`. If that acceptance completes the frame, `o_valid` is high during the cycle after that edge.
- A change shorter than `STABLE_CYCLES` samples is never accepted. A pattern held arbitrarily long is accepted once.
- Identical consecutive frames still produce one `o_valid` per frame.
- Reset asserted mid-frame discards the partial frame. The first `o_valid` after reset needs four fresh acceptances.
- Stability counter width: 8 bits. Timeout counter width: `$clog2(TIMEOUT_CYCLES+1)`.

## Structure
- Shared package `fnd_pkg`:
  - Font constants `FONT_0`..`FONT_9`, `FONT_DP`, `FONT_BLANK`.
  - Code constants `CODE_DP`=`a`, `CODE_ERR`=`e`, `CODE_BLANK`=`f`.
  - These are shared with the display-driver encoder.
- One combinational sub-module `fnd_font_to_bcd`: 8-bit font in, 4-bit code and error flag out. All sequential logic stays in the top.

## Test plan
- Scan fonts `c0`,`f9`,`a4`,`b0` on selects `e`,`d`,`b`,`7`, each held 10 cycles with `STABLE_CYCLES`=4 → one `o_valid`, `o_value`=`3210`, `o_fontErr`=0.
- Same scan, with a 2-cycle glitch font `80` injected on digit 2 before the true value → glitch ignored, `o_value`=`3210`.
- Digit 1 driven with `7f`, digit 3 with `ff`, digit 0 with `55` → `o_value`=`f?ae` with the remaining digit's code in the `?` position, `o_fontErr`=`0001`.
- Hold select `1100` for 6 cycles → `o_selErr`=1, no `o_valid`, mask unchanged. Then `i_clear` → `o_selErr`=0.
- `TIMEOUT_CYCLES`=16, no input activity → `o_stale` rises at cycle 16. A completed frame then drops `o_stale` together with the `o_valid` edge.
- Assert `i_reset_n` low after three digits are accepted, then release and supply only the fourth digit → no `o_valid`, `o_value`=`0000`.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared FND font/code constants and select helpers, used by the capture block
// and the display-driver encoder.
package fnd_pkg;
  localparam logic [7:0] FONT_0     = 8'hc0;
  localparam logic [7:0] FONT_1     = 8'hf9;
  localparam logic [7:0] FONT_2     = 8'ha4;
  localparam logic [7:0] FONT_3     = 8'hb0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hf8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DP    = 8'h7f;
  localparam logic [7:0] FONT_BLANK = 8'hff;

  localparam logic [3:0] CODE_DP    = 4'ha;
  localparam logic [3:0] CODE_ERR   = 4'he;
  localparam logic [3:0] CODE_BLANK = 4'hf;

  typedef enum logic {S_WAIT = 1'b0, S_HELD = 1'b1} cap_state_t;

  // Active-low select is legal only with exactly one bit low.
  function automatic logic sel_legal(input logic [3:0] sel);
    return $countones(~sel) == 1;
  endfunction

  function automatic logic [1:0] sel_idx(input logic [3:0] sel);
    case (sel)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/fnd_font_capture_if.sv
// FND scan bus as seen by the capture block: select/font in, decoded frame out.
interface fnd_font_capture_if;
  logic [3:0]  i_digitSel;
  logic [7:0]  i_font;
  logic [15:0] o_value;
  logic        o_valid;
  logic [3:0]  o_fontErr;
  logic        o_selErr;
  logic        o_stale;

  modport master (output i_digitSel, i_font,
                  input  o_value, o_valid, o_fontErr, o_selErr, o_stale);
  modport slave  (input  i_digitSel, i_font,
                  output o_value, o_valid, o_fontErr, o_selErr, o_stale);
endinterface

// File: rtl/fnd_font_to_bcd.sv
// Combinational inverse of the segment encoder: font back to 4-bit code.
module fnd_font_to_bcd
  import fnd_pkg::*;
(
  input  logic [7:0] i_font,
  output logic [3:0] o_code,
  output logic       o_err
);
  always_comb begin
    o_err = 1'b0;
    case (i_font)
      FONT_0:     o_code = 4'h0;
      FONT_1:     o_code = 4'h1;
      FONT_2:     o_code = 4'h2;
      FONT_3:     o_code = 4'h3;
      FONT_4:     o_code = 4'h4;
      FONT_5:     o_code = 4'h5;
      FONT_6:     o_code = 4'h6;
      FONT_7:     o_code = 4'h7;
      FONT_8:     o_code = 4'h8;
      FONT_9:     o_code = 4'h9;
      FONT_DP:    o_code = CODE_DP;
      FONT_BLANK: o_code = CODE_BLANK;
      default: begin
        o_code = CODE_ERR;
        o_err  = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/fnd_font_capture.sv
// Deglitching capture of a 4-digit multiplexed FND bus into complete frames,
// with select-error and stale-bus reporting.
module fnd_font_capture
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  fnd_font_capture_if.slave bus
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    STB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_PRE   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_INC   = TW'(1);

  logic [3:0]      r_sel;
  logic [7:0]      r_font;
  logic [7:0]      r_stb;
  cap_state_t      r_state, w_state_nxt;
  logic [3:0]      r_mask;
  logic [3:0][3:0] r_stage;
  logic [3:0]      r_stage_err;
  logic [15:0]     r_value;
  logic            r_valid;
  logic [3:0]      r_ferr;
  logic            r_selerr;
  logic            r_stale;
  logic [TW-1:0]   r_tcnt;

  logic            w_chg, w_take, w_legal, w_done, w_ferr;
  logic [1:0]      w_idx;
  logic [3:0]      w_bit, w_code, w_frame_err;
  logic [3:0][3:0] w_frame;

  fnd_font_to_bcd u_dec (.i_font(r_font), .o_code(w_code), .o_err(w_ferr));

  // Compare against the next registered value so the clear lands on the same
  // edge that captures the new pattern.
  assign w_chg = (bus.i_digitSel != r_sel) || (bus.i_font != r_font);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   r_state <= S_WAIT;
    else if (i_clear) r_state <= S_WAIT;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT: if (w_chg) w_state_nxt = S_WAIT;
              else if (r_stb == STB_LAST) w_state_nxt = S_HELD;
      S_HELD: if (w_chg) w_state_nxt = S_WAIT;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w_take      = (r_state == S_WAIT) && (r_stb == STB_LAST);
    w_legal     = sel_legal(r_sel);
    w_idx       = sel_idx(r_sel);
    w_bit       = 4'b0001 << w_idx;
    w_done      = w_take && w_legal && ((r_mask | w_bit) == 4'hf);
    w_frame     = r_stage;
    w_frame_err = r_stage_err;
    w_frame[w_idx]     = w_code;
    w_frame_err[w_idx] = w_ferr;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sel  <= 4'hf;
      r_font <= 8'hff;
      r_stb  <= '0;
    end else begin
      r_sel  <= bus.i_digitSel;
      r_font <= bus.i_font;
      if (i_clear || w_chg)      r_stb <= '0;
      else if (r_state == S_WAIT) r_stb <= r_stb + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mask <= '0; r_stage <= '0; r_stage_err <= '0;
      r_value <= '0; r_valid <= 1'b0; r_ferr <= '0; r_selerr <= 1'b0;
    end else if (i_clear) begin
      r_mask <= '0; r_stage <= '0; r_stage_err <= '0;
      r_value <= '0; r_valid <= 1'b0; r_ferr <= '0; r_selerr <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_take && w_legal) begin
        r_stage     <= w_frame;
        r_stage_err <= w_frame_err;
        r_mask      <= w_done ? 4'h0 : (r_mask | w_bit);
      end
      if (w_take && !w_legal) r_selerr <= 1'b1;
      if (w_done) begin
        r_value <= w_frame;
        r_ferr  <= w_frame_err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tcnt <= '0; r_stale <= 1'b0;
    end else if (i_clear || w_done) begin
      r_tcnt <= '0; r_stale <= 1'b0;
    end else if (r_tcnt != TO_MAX) begin
      r_tcnt <= r_tcnt + TO_INC;
      if (r_tcnt == TO_PRE) r_stale <= 1'b1;
    end
  end

  assign bus.o_value   = r_value;
  assign bus.o_valid   = r_valid;
  assign bus.o_fontErr = r_ferr;
  assign bus.o_selErr  = r_selerr;
  assign bus.o_stale   = r_stale;
endmodule

// File: tb/tb_fnd_font_capture.sv
// Bench for fnd_font_capture: frame vector table, directed corner sequences and
// random scan traffic, all compared every cycle against a run-length reference.
module tb_fnd_font_capture;
  localparam int SC = 4;
  localparam int TO = 16;

  localparam logic [7:0] REF_FONT [12] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92,
                                           8'h82, 8'hf8, 8'h80, 8'h90, 8'h7f, 8'hff};
  localparam logic [3:0] REF_CODE [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                           4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hf};

  typedef struct {
    logic [3:0][7:0] f;
    logic [15:0]     val;
    logic [3:0]      ferr;
  } frame_vec_t;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  fnd_font_capture_if bus();

  fnd_font_capture #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, chk_cnt = 0;

  // Reference state: last registered sample and how many edges it has persisted.
  logic [3:0]  m_rsel;
  logic [7:0]  m_rfont;
  int          m_run;
  logic [3:0]  m_code [4];
  logic        m_err  [4];
  logic [3:0]  m_seen;
  logic [15:0] m_value;
  logic        m_valid;
  logic [3:0]  m_ferr;
  logic        m_selerr, m_stale;
  int          m_tcnt;

  int          nvalid;
  logic [15:0] last_val;
  logic [3:0]  last_ferr;
  logic        prev_stale, stale_before_valid, stale_at_valid;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_decode(input logic [7:0] f, output logic [3:0] c, output logic e);
    c = 4'he; e = 1'b1;
    for (int i = 0; i < 12; i++)
      if (f == REF_FONT[i]) begin c = REF_CODE[i]; e = 1'b0; end
  endfunction

  task automatic model_reset();
    m_rsel = 4'hf; m_rfont = 8'hff; m_run = 1;
    for (int i = 0; i < 4; i++) begin m_code[i] = 4'h0; m_err[i] = 1'b0; end
    m_seen = 4'h0; m_value = 16'h0; m_valid = 1'b0; m_ferr = 4'h0;
    m_selerr = 1'b0; m_stale = 1'b0; m_tcnt = 0;
  endtask

  task automatic model_step(input logic [3:0] sel, input logic [7:0] font, input logic c);
    bit take = (m_run == SC);
    int d = 0;
    m_valid = 1'b0;
    if (c) begin
      for (int i = 0; i < 4; i++) begin m_code[i] = 4'h0; m_err[i] = 1'b0; end
      m_seen = 4'h0; m_value = 16'h0; m_ferr = 4'h0;
      m_selerr = 1'b0; m_stale = 1'b0; m_tcnt = 0;
    end else begin
      if (take) begin
        if ($countones(~m_rsel) == 1) begin
          for (int k = 0; k < 4; k++) if (!m_rsel[k]) d = k;
          ref_decode(m_rfont, m_code[d], m_err[d]);
          m_seen[d] = 1'b1;
          if (m_seen == 4'hf) begin
            m_value = {m_code[3], m_code[2], m_code[1], m_code[0]};
            m_ferr  = {m_err[3], m_err[2], m_err[1], m_err[0]};
            m_valid = 1'b1;
            m_seen  = 4'h0;
          end
        end else m_selerr = 1'b1;
      end
      if (m_valid) m_tcnt = 0;
      else if (m_tcnt < TO) m_tcnt++;
      m_stale = (m_tcnt >= TO);
    end
    if (!c && sel == m_rsel && font == m_rfont) begin
      if (m_run <= SC) m_run++;
    end else m_run = 1;
    m_rsel = sel; m_rfont = font;
  endtask

  task automatic tick(input logic [3:0] sel, input logic [7:0] font, input logic c);
    bus.i_digitSel = sel; bus.i_font = font; clr = c;
    @(posedge clk);
    if (rst_n) model_step(sel, font, c); else model_reset();
    @(negedge clk);
    check("value",   bus.o_value, m_value);
    check("valid",   16'(bus.o_valid), 16'(m_valid));
    check("fontErr", 16'(bus.o_fontErr), 16'(m_ferr));
    check("selErr",  16'(bus.o_selErr), 16'(m_selerr));
    check("stale",   16'(bus.o_stale), 16'(m_stale));
    if (bus.o_valid) begin
      nvalid++; last_val = bus.o_value; last_ferr = bus.o_fontErr;
      stale_before_valid = prev_stale; stale_at_valid = bus.o_stale;
    end
    prev_stale = bus.o_stale;
  endtask

  task automatic hold(input logic [3:0] sel, input logic [7:0] font, input int n);
    repeat (n) tick(sel, font, 1'b0);
  endtask

  function automatic logic [3:0] dsel(input int d);
    logic [3:0] s = 4'b0001 << d;
    return ~s;
  endfunction

  task automatic apply_frame(input logic [3:0][7:0] f);
    for (int d = 0; d < 4; d++) hold(dsel(d), f[d], 10);
  endtask

  frame_vec_t vecs [5];

  initial begin
    vecs[0] = '{{8'hb0, 8'ha4, 8'hf9, 8'hc0}, 16'h3210, 4'h0};
    vecs[1] = '{{8'hf8, 8'h82, 8'h92, 8'h99}, 16'h7654, 4'h0};
    vecs[2] = '{{8'hff, 8'h7f, 8'h90, 8'h80}, 16'hfa98, 4'h0};
    vecs[3] = '{{8'hff, 8'h92, 8'h7f, 8'h55}, 16'hf5ae, 4'h1};
    vecs[4] = '{{8'hfe, 8'h81, 8'hc1, 8'h00}, 16'heeee, 4'hf};

    nvalid = 0; prev_stale = 1'b0; stale_before_valid = 1'b0; stale_at_valid = 1'b1;
    last_val = 16'h0; last_ferr = 4'h0;
    bus.i_digitSel = 4'hf; bus.i_font = 8'hff;
    model_reset();
    #1;
    check("rst_value",   bus.o_value, 16'h0);
    check("rst_valid",   16'(bus.o_valid), 16'h0);
    check("rst_fontErr", 16'(bus.o_fontErr), 16'h0);
    check("rst_selErr",  16'(bus.o_selErr), 16'h0);
    check("rst_stale",   16'(bus.o_stale), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle bus: stale appears exactly on the 16th edge after reset release.
    hold(4'hf, 8'hff, 15);
    check("stale_pre16", 16'(bus.o_stale), 16'h0);
    hold(4'hf, 8'hff, 1);
    check("stale_at16", 16'(bus.o_stale), 16'h1);

    // Vector table; the first frame also shows stale dropping with o_valid.
    for (int v = 0; v < 5; v++) begin
      if (v != 0) tick(4'hf, 8'hff, 1'b1);
      nvalid = 0;
      apply_frame(vecs[v].f);
      check("frame_nvalid", 16'(nvalid), 16'h1);
      check("frame_value", last_val, vecs[v].val);
      check("frame_fontErr", 16'(last_ferr), 16'(vecs[v].ferr));
      if (v == 0) begin
        check("stale_before_valid", 16'(stale_before_valid), 16'h1);
        check("stale_with_valid", 16'(stale_at_valid), 16'h0);
      end
    end

    // Short glitch on digit 2 must not be accepted.
    tick(4'hf, 8'hff, 1'b1);
    nvalid = 0;
    hold(4'he, 8'hc0, 10);
    hold(4'hd, 8'hf9, 10);
    hold(4'hb, 8'h80, 2);
    hold(4'hb, 8'ha4, 10);
    hold(4'h7, 8'hb0, 10);
    check("glitch_nvalid", 16'(nvalid), 16'h1);
    check("glitch_value", last_val, 16'h3210);

    // Illegal select: sticky error, staging and mask survive.
    tick(4'he, 8'hc0, 1'b1);
    check("clr_selErr", 16'(bus.o_selErr), 16'h0);
    nvalid = 0;
    hold(4'he, 8'hc0, 8);
    hold(4'hc, 8'hc0, 6);
    check("sel_selErr", 16'(bus.o_selErr), 16'h1);
    check("sel_nvalid", 16'(nvalid), 16'h0);
    hold(4'hd, 8'hf9, 10);
    hold(4'hb, 8'ha4, 10);
    hold(4'h7, 8'hb0, 10);
    check("sel_frame_nvalid", 16'(nvalid), 16'h1);
    check("sel_frame_value", last_val, 16'h3210);
    tick(4'h7, 8'hb0, 1'b1);
    check("sel_cleared", 16'(bus.o_selErr), 16'h0);

    // Reset mid-frame discards three accepted digits.
    nvalid = 0;
    hold(4'he, 8'h99, 10);
    hold(4'hd, 8'h92, 10);
    hold(4'hb, 8'h82, 10);
    rst_n = 1'b0;
    model_reset();
    tick(4'h7, 8'hf8, 1'b0);
    rst_n = 1'b1;
    hold(4'h7, 8'hf8, 10);
    check("rst_mid_nvalid", 16'(nvalid), 16'h0);
    check("rst_mid_value", bus.o_value, 16'h0);

    // Random scan traffic against the reference.
    for (int seg = 0; seg < 150; seg++) begin
      logic [3:0] s;
      logic [7:0] f;
      int n;
      logic c;
      c = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 8) s = dsel($urandom_range(0, 3));
      else s = 4'($urandom);
      if ($urandom_range(0, 9) < 7) f = REF_FONT[$urandom_range(0, 11)];
      else f = 8'($urandom);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) tick(s, f, (i == 0) ? c : 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
